// File: rtl/toggle_activity_counter_pkg.sv
// Shared types and sizing helpers for the toggle activity counter.
package toggle_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int unsigned DEF_WEIGHT_W = 4;

    // Width of the capacitance-weighted accumulator.
    function automatic int unsigned acc_width(input int unsigned cnt_w,
                                              input int unsigned weight_w);
        return cnt_w + weight_w;
    endfunction

endpackage

// File: rtl/toggle_activity_counter_if.sv
// Control, sample and result bundle between the monitor and its environment.
interface toggle_activity_counter_if
    import toggle_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned WEIGHT_W = DEF_WEIGHT_W,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned WIN_W    = 16
);

    localparam int unsigned ACC_W = acc_width(CNT_W, WEIGHT_W);

    logic                      start;
    logic [WIN_W-1:0]          window_len;
    logic [WIDTH-1:0]          sig_in;
    logic [WIDTH*WEIGHT_W-1:0] weights;
    logic                      busy;
    logic [CNT_W-1:0]          toggle_total;
    logic [ACC_W-1:0]          weighted_sum;
    logic                      overflow;
    logic                      out_valid;
    logic                      out_ready;

    modport master (
        output start, window_len, sig_in, weights, out_ready,
        input  busy, toggle_total, weighted_sum, overflow, out_valid
    );

    modport slave (
        input  start, window_len, sig_in, weights, out_ready,
        output busy, toggle_total, weighted_sum, overflow, out_valid
    );

endinterface

// File: rtl/toggle_activity_counter_weigh.sv
// Per-cycle toggle weighing: popcount and weight sum of the toggled nets.
module toggle_weigh #(
    parameter  int unsigned WIDTH    = 8,
    parameter  int unsigned WEIGHT_W = 4,
    localparam int unsigned PC_W     = $clog2(WIDTH + 1),
    localparam int unsigned INC_W    = WEIGHT_W + PC_W
) (
    input  logic [WIDTH-1:0]          t,
    input  logic [WIDTH*WEIGHT_W-1:0] weights,
    output logic [PC_W-1:0]           popcount,
    output logic [INC_W-1:0]          weighted_inc
);

    // Sum the count and the weight of every net that toggled this cycle.
    always_comb begin
        popcount     = '0;
        weighted_inc = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (t[i]) begin
                popcount     = popcount + PC_W'(1);
                weighted_inc = weighted_inc + INC_W'(weights[i*WEIGHT_W +: WEIGHT_W]);
            end
        end
    end

endmodule

// File: rtl/toggle_activity_counter.sv
// Windowed switching-activity monitor with saturating raw and weighted counts.
module toggle_activity_counter
    import toggle_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned WEIGHT_W = DEF_WEIGHT_W,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned WIN_W    = 16
) (
    input logic                      clk,
    input logic                      rst,
    toggle_activity_counter_if.slave bus
);

    localparam int unsigned ACC_W = acc_width(CNT_W, WEIGHT_W);
    localparam int unsigned PC_W  = $clog2(WIDTH + 1);
    localparam int unsigned INC_W = WEIGHT_W + PC_W;

    state_e           state_q, state_d;
    logic [WIN_W-1:0] wlen_q, wlen_d;
    logic [WIN_W-1:0] scnt_q, scnt_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [CNT_W-1:0] toggle_q, toggle_d;
    logic [ACC_W-1:0] wsum_q, wsum_d;
    logic             ovf_q, ovf_d;

    logic [PC_W-1:0]  pc;
    logic [INC_W-1:0] inc;
    logic [CNT_W:0]   cnt_sum;
    logic [ACC_W:0]   w_sum;

    toggle_weigh #(
        .WIDTH    (WIDTH),
        .WEIGHT_W (WEIGHT_W)
    ) u_weigh (
        .t            (bus.sig_in ^ prev_q),
        .weights      (bus.weights),
        .popcount     (pc),
        .weighted_inc (inc)
    );

    // One spare carry bit per accumulator flags a clamp.
    assign cnt_sum = {1'b0, toggle_q} + (CNT_W+1)'(pc);
    assign w_sum   = {1'b0, wsum_q} + (ACC_W+1)'(inc);

    // State and datapath registers; reset discards any window in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            wlen_q   <= '0;
            scnt_q   <= '0;
            prev_q   <= '0;
            toggle_q <= '0;
            wsum_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wlen_q   <= wlen_d;
            scnt_q   <= scnt_d;
            prev_q   <= prev_d;
            toggle_q <= toggle_d;
            wsum_q   <= wsum_d;
            ovf_q    <= ovf_d;
        end
    end

    // Next-state and accumulation logic for the window sequence.
    always_comb begin
        state_d  = state_q;
        wlen_d   = wlen_q;
        scnt_d   = scnt_q;
        prev_d   = prev_q;
        toggle_d = toggle_q;
        wsum_d   = wsum_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.start && (bus.window_len != '0)) begin
                    wlen_d   = bus.window_len;
                    scnt_d   = '0;
                    toggle_d = '0;
                    wsum_d   = '0;
                    ovf_d    = 1'b0;
                    state_d  = PRIME;
                end
            end
            PRIME: begin
                prev_d  = bus.sig_in;
                state_d = COUNT;
            end
            COUNT: begin
                prev_d   = bus.sig_in;
                scnt_d   = scnt_q + WIN_W'(1);
                toggle_d = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
                wsum_d   = w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];
                if (cnt_sum[CNT_W] || w_sum[ACC_W]) begin
                    ovf_d = 1'b1;
                end
                if (scnt_d == wlen_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy         = (state_q != IDLE);
    assign bus.out_valid    = (state_q == DONE);
    assign bus.toggle_total = toggle_q;
    assign bus.weighted_sum = wsum_q;
    assign bus.overflow     = ovf_q;

endmodule

// File: tb/tb_toggle_activity_counter.sv
// Bench: two monitors (wide and narrow raw counter) fed identical stimulus and
// compared against a window-level reference model.
module tb_toggle_activity_counter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] window_len = '0;
    logic [7:0]  sig_in = '0;
    logic [31:0] wbus = '0;
    logic        out_ready = 1'b0;

    int errors = 0;
    int checks = 0;

    logic [7:0]  smp [0:15];
    int          wts [0:7];

    longint exp_tot_m, exp_ws_m, exp_ovf_m;
    longint exp_tot_s, exp_ws_s, exp_ovf_s;

    toggle_activity_counter_if #(.WIDTH(8), .WEIGHT_W(4), .CNT_W(16), .WIN_W(16)) ifm ();
    toggle_activity_counter_if #(.WIDTH(8), .WEIGHT_W(4), .CNT_W(4),  .WIN_W(16)) ifs ();

    assign ifm.start = start;  assign ifm.window_len = window_len;
    assign ifm.sig_in = sig_in; assign ifm.weights = wbus;
    assign ifm.out_ready = out_ready;
    assign ifs.start = start;  assign ifs.window_len = window_len;
    assign ifs.sig_in = sig_in; assign ifs.weights = wbus;
    assign ifs.out_ready = out_ready;

    toggle_activity_counter #(.WIDTH(8), .WEIGHT_W(4), .CNT_W(16), .WIN_W(16)) dut_m (
        .clk (clk), .rst (rst), .bus (ifm)
    );
    toggle_activity_counter #(.WIDTH(8), .WEIGHT_W(4), .CNT_W(4), .WIN_W(16)) dut_s (
        .clk (clk), .rst (rst), .bus (ifs)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_weights();
        for (int i = 0; i < 8; i++) wbus[i*4 +: 4] = 4'(wts[i]);
    endtask

    // Reference: total and weighted toggle counts over the whole window, then
    // clamp to each accumulator's range; overflow means the true sum exceeded it.
    task automatic model(input int n);
        longint tot = 0;
        longint ws  = 0;
        for (int k = 1; k <= n; k++)
            for (int b = 0; b < 8; b++)
                if (smp[k][b] != smp[k-1][b]) begin
                    tot += 1;
                    ws  += wts[b];
                end
        exp_tot_m = (tot > 65535) ? 65535 : tot;
        exp_ws_m  = (ws > 1048575) ? 1048575 : ws;
        exp_ovf_m = (tot > 65535 || ws > 1048575) ? 1 : 0;
        exp_tot_s = (tot > 15) ? 15 : tot;
        exp_ws_s  = (ws > 255) ? 255 : ws;
        exp_ovf_s = (tot > 15 || ws > 255) ? 1 : 0;
    endtask

    task automatic check_results(input string tag);
        check({tag, "_tot_m"}, ifm.toggle_total, exp_tot_m);
        check({tag, "_ws_m"},  ifm.weighted_sum, exp_ws_m);
        check({tag, "_ovf_m"}, ifm.overflow,     exp_ovf_m);
        check({tag, "_tot_s"}, ifs.toggle_total, exp_tot_s);
        check({tag, "_ws_s"},  ifs.weighted_sum, exp_ws_s);
        check({tag, "_ovf_s"}, ifs.overflow,     exp_ovf_s);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"},  ifm.busy + ifs.busy, 0);
        check({tag, "_valid"}, ifm.out_valid + ifs.out_valid, 0);
        check({tag, "_tot"},   ifm.toggle_total + ifs.toggle_total, 0);
        check({tag, "_ws"},    ifm.weighted_sum + ifs.weighted_sum, 0);
        check({tag, "_ovf"},   ifm.overflow + ifs.overflow, 0);
    endtask

    // Runs one window from smp[0..n] and waits rdy_dly cycles before accepting.
    task automatic run_window(input int n, input int rdy_dly, input bit noisy);
        set_weights();
        model(n);
        start = 1'b1; window_len = 16'(n); sig_in = 8'($urandom);
        tick();
        start = 1'b0;
        check("prime_busy",  ifm.busy, 1);
        check("prime_valid", ifm.out_valid, 0);
        sig_in = smp[0];
        tick();
        for (int k = 1; k <= n; k++) begin
            sig_in = smp[k];
            if (noisy) begin
                start = 1'($urandom_range(0, 1));
                window_len = 16'($urandom);
            end
            tick();
            start = 1'b0;
            if (k < n) check("count_valid", ifm.out_valid | ifs.out_valid, 0);
        end
        check("done_valid_m", ifm.out_valid, 1);
        check("done_valid_s", ifs.out_valid, 1);
        check_results("done");
        for (int d = 0; d < rdy_dly; d++) begin
            out_ready = 1'b0;
            start = 1'($urandom_range(0, 1));
            window_len = 16'($urandom_range(1, 9));
            sig_in = 8'($urandom);
            tick();
            check("hold_valid", ifm.out_valid & ifs.out_valid, 1);
            check_results("hold");
        end
        start = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("acc_busy",  ifm.busy | ifs.busy, 0);
        check("acc_valid", ifm.out_valid | ifs.out_valid, 0);
        check_results("acc");
    endtask

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        check_zero("reset");

        // 2:1 mux nets {out,b,a} in bits [2:0], unit weights
        for (int i = 0; i < 8; i++) wts[i] = 1;
        smp[0] = 8'b010; smp[1] = 8'b101; smp[2] = 8'b100;
        smp[3] = 8'b111; smp[4] = 8'b011; smp[5] = 8'b100;
        run_window(5, 2, 1'b0);
        check("mux_tot", ifm.toggle_total, 10);
        check("mux_ws",  ifm.weighted_sum, 10);

        // weights {3,2,1}, net2 toggles every sample
        wts[0] = 1; wts[1] = 2; wts[2] = 3;
        smp[0] = 8'h00; smp[1] = 8'h04; smp[2] = 8'h00;
        smp[3] = 8'h04; smp[4] = 8'h00;
        run_window(4, 0, 1'b1);
        check("w_tot", ifm.toggle_total, 4);
        check("w_ws",  ifm.weighted_sum, 12);
        check("w_ovf", ifm.overflow, 0);

        // all bits toggling: narrow raw counter saturates, weighted does not
        for (int i = 0; i < 8; i++) wts[i] = 1;
        smp[0] = 8'h00; smp[1] = 8'hFF; smp[2] = 8'h00; smp[3] = 8'hFF;
        run_window(3, 10, 1'b0);
        check("sat_tot", ifs.toggle_total, 15);
        check("sat_ovf", ifs.overflow, 1);
        check("sat_ws",  ifs.weighted_sum, 24);

        // zero-length start is ignored and leaves results untouched
        start = 1'b1; window_len = '0;
        tick();
        start = 1'b0;
        check("zero_busy", ifm.busy | ifs.busy, 0);
        check_results("zero");
        tick();
        check("zero_busy2", ifm.busy | ifs.busy, 0);

        // reset in the middle of a window
        start = 1'b1; window_len = 16'd10;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sig_in = 8'($urandom);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_zero("midrst");
        for (int i = 0; i <= 2; i++) smp[i] = 8'($urandom);
        run_window(2, 1, 1'b0);

        // randomized windows
        for (int w = 0; w < 25; w++) begin
            int n;
            n = $urandom_range(1, 12);
            for (int i = 0; i < 8; i++) wts[i] = $urandom_range(0, 15);
            for (int i = 0; i <= n; i++) smp[i] = 8'($urandom);
            run_window(n, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
